// File: rtl/vga_line_loader.sv
// Fetches one scan line per line_req from frame memory into a line buffer.
// Define VGA_LINE_DOUBLE_BUFFER_EN for a front/back bank pair swapped at line completion.
module vga_line_loader #(
    parameter int PIXEL_DEPTH   = 4,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_WIDTH    = 19
) (
    input  logic                                    clock_25mhz,
    input  logic                                    reset,
    input  logic                                    line_req,
    input  logic                                    frame_start,
    output logic                                    mem_rd,
    output logic [ADDR_WIDTH-1:0]                   mem_addr,
    input  logic [3*PIXEL_DEPTH-1:0]                mem_data,
    output logic [SCREEN_WIDTH*3*PIXEL_DEPTH-1:0]   scan_line,
    output logic                                    line_ready,
    output logic                                    busy,
    output logic [9:0]                              line_num,
    output logic                                    overrun
);
    localparam int PW = 3 * PIXEL_DEPTH;
    localparam int XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                  state;
    logic [XW-1:0]           x;
    logic [XW-1:0]           wr_idx;
    logic                    wr_vld;
    logic [ADDR_WIDTH-1:0]   base;

`ifdef VGA_LINE_DOUBLE_BUFFER_EN
    logic                                 front;
    logic [1:0][SCREEN_WIDTH-1:0][PW-1:0] bank;
    assign scan_line = bank[front];
`else
    logic [SCREEN_WIDTH-1:0][PW-1:0]      bank;
    assign scan_line = bank;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            state      <= IDLE;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            line_ready <= 1'b0;
            line_num   <= '0;
            overrun    <= 1'b0;
            base       <= '0;
            x          <= '0;
            wr_vld     <= 1'b0;
            wr_idx     <= '0;
`ifdef VGA_LINE_DOUBLE_BUFFER_EN
            front      <= 1'b0;
`endif
        end else begin
            // The beat still in flight when a load is aborted must not land.
            wr_vld     <= mem_rd && !frame_start;
            wr_idx     <= x;
            line_ready <= 1'b0;
            if (line_req && state != IDLE)
                overrun <= 1'b1;
            if (frame_start) begin
                overrun  <= 1'b0;
                line_num <= '0;
                base     <= '0;
                x        <= '0;
                mem_addr <= '0;
                if (state == IDLE && line_req) begin
                    state  <= FETCH;
                    mem_rd <= 1'b1;
                end else begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: if (line_req) begin
                        state    <= FETCH;
                        mem_rd   <= 1'b1;
                        mem_addr <= base;
                        x        <= '0;
                    end
                    FETCH: if (x == XW'(SCREEN_WIDTH - 1)) begin
                        state    <= DRAIN;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        x        <= x + 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                    DRAIN: begin
                        state      <= DONE;
                        line_ready <= 1'b1;
`ifdef VGA_LINE_DOUBLE_BUFFER_EN
                        front      <= ~front;
`endif
                    end
                    DONE: begin
                        state <= IDLE;
                        if (line_num == 10'(SCREEN_HEIGHT - 1)) begin
                            line_num <= '0;
                            base     <= '0;
                        end else begin
                            line_num <= line_num + 1'b1;
                            base     <= base + ADDR_WIDTH'(SCREEN_WIDTH);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset)
            bank <= '0;
        else if (wr_vld)
`ifdef VGA_LINE_DOUBLE_BUFFER_EN
            bank[~front][wr_idx] <= mem_data;
`else
            bank[wr_idx] <= mem_data;
`endif
    end
endmodule

// File: tb/tb_vga_line_loader.sv
// Directed/randomized bench for vga_line_loader against a line-level reference model.
module tb_vga_line_loader;
    localparam int PD = 4;
    localparam int W  = 320;
    localparam int H  = 8;
    localparam int AW = 19;
    localparam int PW = 3 * PD;
`ifdef VGA_LINE_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset, line_req, frame_start;
    logic            mem_rd, line_ready, busy, overrun;
    logic [AW-1:0]   mem_addr;
    logic [PW-1:0]   mem_data;
    logic [W*PW-1:0] scan_line;
    logic [9:0]      line_num;

    int checks = 0;
    int errors = 0;
    int lr_cnt = 0;
    logic [11:0] salt = '0;

    // Reference model: the line number, overrun flag, visible line and the line being loaded.
    int            m_line = 0;
    bit            m_ovr  = 1'b0;
    logic [PW-1:0] shown [W];
    logic [PW-1:0] newl  [W];

    vga_line_loader #(
        .PIXEL_DEPTH(PD), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW)
    ) dut (
        .clock_25mhz(clk), .reset(reset), .line_req(line_req), .frame_start(frame_start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .scan_line(scan_line),
        .line_ready(line_ready), .busy(busy), .line_num(line_num), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Frame memory: one-cycle latency, content = address[11:0] ^ salt, garbage when not read.
    always @(posedge clk)
        mem_data <= mem_rd ? (mem_addr[11:0] ^ salt) : 12'($urandom);

    always @(negedge clk)
        if (line_ready === 1'b1) lr_cnt++;

    function automatic logic [PW-1:0] pix(input int a);
        logic [31:0] aa;
        aa = a;
        return aa[11:0] ^ salt;
    endfunction

    function automatic logic [W*PW-1:0] exp_scan(input int upto);
        logic [W*PW-1:0] v;
        for (int j = 0; j < W; j++)
            v[j*PW +: PW] = (j <= upto) ? newl[j] : shown[j];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_scan(input string tag, input int upto);
        logic [W*PW-1:0] ev;
        int bad_j;
        ev = exp_scan(upto);
        bad_j = -1;
        for (int j = W - 1; j >= 0; j--)
            if (scan_line[j*PW +: PW] !== ev[j*PW +: PW]) bad_j = j;
        checks++;
        assert (scan_line === ev) else begin
            errors++;
            $error("FAIL %s: pixel %0d observed %0h expected %0h", tag, bad_j,
                   scan_line[bad_j*PW +: PW], ev[bad_j*PW +: PW]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"},    mem_rd, 0);
        check({tag, "_addr"},  mem_addr, 0);
        check({tag, "_ready"}, line_ready, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_line"},  line_num, m_line);
        check({tag, "_ovr"},   overrun, m_ovr);
    endtask

    // One line load. fs_at/req_at/rst_at give the fetch cycle (1..W) at which frame_start,
    // a stray line_req or reset is applied; 0 means never.
    task automatic load(input logic [11:0] s, input bit fs_idle, input int fs_at,
                        input int req_at, input int rst_at, output int first_addr);
        int base, lr0;
        bit bad, sbad;
        salt = s;
        if (fs_idle) begin m_line = 0; m_ovr = 1'b0; end
        base = m_line * W;
        for (int j = 0; j < W; j++) newl[j] = pix(base + j);
        lr0 = lr_cnt;
        line_req = 1'b1; frame_start = fs_idle;
        @(negedge clk);
        line_req = 1'b0; frame_start = 1'b0;
        first_addr = int'(mem_addr);
        bad = 1'b0; sbad = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (mem_rd !== 1'b1 || mem_addr !== AW'(base + k - 1) || line_ready !== 1'b0 || busy !== 1'b1)
                bad = 1'b1;
            if (scan_line !== exp_scan(DB ? -1 : k - 3)) sbad = 1'b1;
            if (k == req_at) line_req = 1'b1;
            if (k == fs_at) frame_start = 1'b1;
            if (k == rst_at) reset = 1'b1;
            @(negedge clk);
            line_req = 1'b0; frame_start = 1'b0;
            if (k == fs_at || k == rst_at) begin
                check("fetch_seq_pre_abort", bad, 0);
                check("scan_pre_abort", sbad, 0);
                if (k == rst_at) begin
                    for (int j = 0; j < W; j++) shown[j] = '0;
                end else if (!DB) begin
                    for (int j = 0; j <= k - 2; j++) shown[j] = newl[j];
                end
                m_line = 0; m_ovr = 1'b0;
                check_idle_outputs("abort");
                check_scan("scan_abort", -1);
                reset = 1'b0;
                @(negedge clk);
                check_scan("scan_abort_settled", -1);
                check("abort_no_ready", lr_cnt, lr0);
                return;
            end
        end
        check("fetch_seq", bad, 0);
        check("scan_during_fetch", sbad, 0);
        if (req_at > 0) m_ovr = 1'b1;
        check("drain_rd", mem_rd, 0);
        check("drain_addr", mem_addr, 0);
        check("drain_busy", busy, 1);
        check("drain_ready", line_ready, 0);
        check_scan("scan_drain", DB ? -1 : W - 2);
        @(negedge clk);
        check("done_ready", line_ready, 1);
        check("done_busy", busy, 1);
        for (int j = 0; j < W; j++) shown[j] = newl[j];
        check_scan("scan_done", -1);
        @(negedge clk);
        m_line = (m_line + 1) % H;
        check_idle_outputs("after_done");
        check("ready_count", lr_cnt, lr0 + 1);
    endtask

    initial begin
        int fa;
        reset = 1'b1; line_req = 1'b0; frame_start = 1'b0;
        for (int j = 0; j < W; j++) begin shown[j] = '0; newl[j] = '0; end
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_scan("reset_scan", -1);
        reset = 1'b0;
        @(negedge clk);

        // First line with memory = address: pixel j reads back as j.
        load(12'h000, 1'b0, 0, 0, 0, fa);
        check("first_addr0", fa, 0);
        check("pix5", scan_line[5*PW +: PW], 5);
        check("pix_last", scan_line[(W-1)*PW +: PW], W - 1);
        check("line_num1", line_num, 1);

        // Stray line_req mid-fetch: flagged, ignored, cleared by frame_start.
        load(12'($urandom), 1'b0, 0, 100, 0, fa);
        check("overrun_set", overrun, 1);
        repeat (3) begin
            @(negedge clk);
            check("no_extra_fetch_busy", busy, 0);
            check("no_extra_fetch_rd", mem_rd, 0);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        m_line = 0; m_ovr = 1'b0;
        check_idle_outputs("frame_start_idle");

        // Advance to line 5, then abort it with frame_start partway through.
        while (m_line < 5) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            load(12'($urandom), 1'b0, 0, 0, 0, fa);
        end
        load(12'($urandom), 1'b0, 300, 0, 0, fa);
        check("abort_base", fa, 5 * W);

        // frame_start together with line_req in IDLE restarts at line 0.
        load(12'($urandom), 1'b0, 0, 0, 0, fa);
        load(12'($urandom), 1'b1, 0, 0, 0, fa);
        check("fs_req_addr0", fa, 0);

        // Run to the last line of the frame and wrap.
        while (m_line != H - 1) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            load(12'($urandom), 1'b0, 0, 0, 0, fa);
        end
        load(12'($urandom), 1'b0, 0, 0, 0, fa);
        check("last_base", fa, (H - 1) * W);
        check("wrap_line", line_num, 0);
        load(12'($urandom), 1'b0, 0, 0, 0, fa);
        check("wrap_addr0", fa, 0);

        // Reset partway through a fetch, then a clean load.
        load(12'($urandom), 1'b0, 0, 0, 10, fa);
        load(12'($urandom), 1'b0, 0, 0, 0, fa);
        check("post_reset_addr0", fa, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
